bra_resolve_queue: RTL and testbench

- Sits directly downstream of the branch ALU and upstream of the ROB.
- Captures each resolved-branch record (ROB index, predicted bit, actual bit) and buffers it in an in-order FIFO.
- Flags mispredictions and delivers records to the ROB over a valid/ready handshake.
- Discards stale results after a pipeline flush for a programmable hold window.

---
 rtl/bra_resolve_queue.sv | 163 ++++++++++++++++
 tb/tb_bra_resolve_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bra_resolve_queue.sv
// Purpose : in-order buffer of resolved-branch records between the branch ALU and the ROB; flags mispredicts and drops stale results after a flush.
// Latency : a record pushed in cycle N reaches the head in cycle N+1 at the earliest (no bypass).
// Backpressure: in_ready drops when full or while holding after a flush; the ROB throttles the head via rob_ready.
// Optional feature macro: BRA_RESOLVE_STATS_EN adds the stat_resolved / stat_mispred pop counters.
module bra_resolve_queue #(
    parameter int ROB_IDX_W  = 4,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [ROB_IDX_W-1:0] in_index,
    input  logic [1:0]           in_result,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 rob_valid,
    input  logic                 rob_ready,
    output logic [ROB_IDX_W-1:0] rob_index,
    output logic                 rob_taken,
    output logic                 rob_mispredict,
    output logic                 overflow,
`ifdef BRA_RESOLVE_STATS_EN
    output logic [15:0]          stat_resolved,
    output logic [15:0]          stat_mispred,
`endif
    output logic                 holding
);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] index;
        logic                 pred;
        logic                 act;
    } entry_t;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [3:0]     HOLD_LD  = 4'(FLUSH_HOLD);

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state;
    state_t           state_nxt;
    logic [3:0]       hold_cnt;
    logic [3:0]       hold_cnt_nxt;
    logic             push;
    logic             pop;
    logic             ovf_attempt;

    // A flush wins over everything: neither the push nor the pop of that cycle is honoured.
    assign push        = in_valid && in_ready && !flush;
    assign pop         = rob_valid && rob_ready && !flush;
    assign ovf_attempt = in_valid && (count == FULL_CNT) && (state == RUN);
    assign head        = mem[rd_ptr];

    // FSM state register and hold-window counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // FSM next state: enter HOLD on flush, count the window down, re-arm on a repeat flush.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            RUN: begin
                if (flush && (HOLD_LD != 4'd0)) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HOLD_LD;
                end
            end
            HOLD: begin
                if (flush) begin
                    hold_cnt_nxt = HOLD_LD;
                end else if (hold_cnt == 4'd1) begin
                    state_nxt    = RUN;
                    hold_cnt_nxt = 4'd0;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
        endcase
    end

    // FSM outputs: accept only when running and not full; both derived from registered state.
    always_comb begin
        holding  = (state == HOLD);
        in_ready = (count != FULL_CNT) && (state == RUN);
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (ovf_attempt) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Record storage; contents are only observed through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{index: in_index, pred: in_result[1], act: in_result[0]};
        end
    end

    // Head presentation, forced to zero when empty so the ROB never sees stale fields.
    always_comb begin
        rob_valid      = (count != '0);
        rob_index      = rob_valid ? head.index : '0;
        rob_taken      = rob_valid ? head.act : 1'b0;
        rob_mispredict = rob_valid ? (head.pred ^ head.act) : 1'b0;
    end

`ifdef BRA_RESOLVE_STATS_EN
    // Pop statistics; survive flushes and wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_resolved <= 16'd0;
            stat_mispred  <= 16'd0;
        end else if (pop) begin
            stat_resolved <= stat_resolved + 16'd1;
            if (rob_mispredict) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bra_resolve_queue.sv
// Purpose : directed self-checking bench for bra_resolve_queue.
// Latency : inputs change 1ns after a rising edge; outputs are checked at that same point.
// Backpressure: rob_ready and in_valid are driven explicitly by each scenario.
module tb_bra_resolve_queue;

    localparam int ROB_IDX_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [ROB_IDX_W-1:0] in_index;
    logic [1:0]           in_result;
    logic                 in_ready;
    logic                 flush;
    logic                 rob_valid;
    logic                 rob_ready;
    logic [ROB_IDX_W-1:0] rob_index;
    logic                 rob_taken;
    logic                 rob_mispredict;
    logic                 overflow;
    logic                 holding;
`ifdef BRA_RESOLVE_STATS_EN
    logic [15:0]          stat_resolved;
    logic [15:0]          stat_mispred;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    bra_resolve_queue #(
        .ROB_IDX_W (ROB_IDX_W),
        .DEPTH     (4),
        .PTR_W     (2),
        .FLUSH_HOLD(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_index      (in_index),
        .in_result     (in_result),
        .in_ready      (in_ready),
        .flush         (flush),
        .rob_valid     (rob_valid),
        .rob_ready     (rob_ready),
        .rob_index     (rob_index),
        .rob_taken     (rob_taken),
        .rob_mispredict(rob_mispredict),
        .overflow      (overflow),
`ifdef BRA_RESOLVE_STATS_EN
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred),
`endif
        .holding       (holding)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_index  = '0;
        in_result = 2'b00;
        flush     = 1'b0;
        rob_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        total++; if (rob_valid !== 1'b0) $display("FAIL rst_rob_valid got=%b want=0", rob_valid); else pass_cnt++;
        total++; if (rob_index !== 4'd0) $display("FAIL rst_rob_index got=%0d want=0", rob_index); else pass_cnt++;
        total++; if ({rob_taken, rob_mispredict} !== 2'b00) $display("FAIL rst_fields got=%b%b want=00", rob_taken, rob_mispredict); else pass_cnt++;
        rst = 1'b1;
        step();
        total++; if (rob_valid !== 1'b0) $display("FAIL idle_rob_valid got=%b want=0", rob_valid); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got=%b want=1", in_ready); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL idle_overflow got=%b want=0", overflow); else pass_cnt++;
        total++; if (holding !== 1'b0) $display("FAIL idle_holding got=%b want=0", holding); else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_index = 4'd5; in_result = 2'b10;
        step();
        in_valid = 1'b0;
        total++; if (rob_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", rob_valid); else pass_cnt++;
        total++; if (rob_index !== 4'd5) $display("FAIL single_index got=%0d want=5", rob_index); else pass_cnt++;
        total++; if (rob_taken !== 1'b0) $display("FAIL single_taken got=%b want=0", rob_taken); else pass_cnt++;
        total++; if (rob_mispredict !== 1'b1) $display("FAIL single_mispred got=%b want=1", rob_mispredict); else pass_cnt++;
        rob_ready = 1'b1;
        step();
        rob_ready = 1'b0;
        total++; if (rob_valid !== 1'b0) $display("FAIL single_pop got=%b want=0", rob_valid); else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_index = 4'(i); in_result = 2'b01;
            step();
        end
        total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b want=0", in_ready); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL full_pre_overflow got=%b want=0", overflow); else pass_cnt++;
        in_index = 4'd9;
        step();
        in_valid = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL overflow_set got=%b want=1", overflow); else pass_cnt++;
        rob_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (rob_valid !== 1'b1 || rob_index !== 4'(i))
                $display("FAIL drain_head%0d got=%b/%0d want=1/%0d", i, rob_valid, rob_index, i);
            else pass_cnt++;
            step();
        end
        rob_ready = 1'b0;
        total++; if (rob_valid !== 1'b0) $display("FAIL drain_empty got=%b/%0d want=0 (no index 9)", rob_valid, rob_index); else pass_cnt++;
        total++; if (overflow !== 1'b1) $display("FAIL overflow_sticky got=%b want=1", overflow); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_index = 4'd7; in_result = 2'b11;
        step();
        in_index = 4'd8; in_result = 2'b00; rob_ready = 1'b1;
        total++; if (rob_index !== 4'd7) $display("FAIL b2b_first got=%0d want=7", rob_index); else pass_cnt++;
        step();
        in_valid = 1'b0; rob_ready = 1'b0;
        total++; if (rob_valid !== 1'b1 || rob_index !== 4'd8) $display("FAIL b2b_head got=%b/%0d want=1/8", rob_valid, rob_index); else pass_cnt++;
        rob_ready = 1'b1;
        step();
        rob_ready = 1'b0;
        total++; if (rob_valid !== 1'b0) $display("FAIL b2b_count got=%b want=0 after single pop", rob_valid); else pass_cnt++;
    endtask

    task automatic test_flush_hold();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_index = 4'(i); in_result = 2'b00;
            step();
        end
        flush = 1'b1; in_index = 4'd6;
        step();
        flush = 1'b0;
        total++; if (rob_valid !== 1'b0) $display("FAIL flush_empty got=%b want=0", rob_valid); else pass_cnt++;
        total++; if (holding !== 1'b1) $display("FAIL hold_c1 got=%b want=1", holding); else pass_cnt++;
        total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready got=%b want=0", in_ready); else pass_cnt++;
        step();
        total++; if (holding !== 1'b1 || rob_valid !== 1'b0) $display("FAIL hold_c2 got=%b/%b want=1/0", holding, rob_valid); else pass_cnt++;
        step();
        total++; if (holding !== 1'b0 || rob_valid !== 1'b0) $display("FAIL hold_exit got=%b/%b want=0/0", holding, rob_valid); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL hold_exit_ready got=%b want=1", in_ready); else pass_cnt++;
        in_index = 4'd3; in_result = 2'b11;
        step();
        in_valid = 1'b0;
        total++; if (rob_valid !== 1'b1 || rob_index !== 4'd3) $display("FAIL post_hold_head got=%b/%0d want=1/3", rob_valid, rob_index); else pass_cnt++;
        total++; if (rob_taken !== 1'b1 || rob_mispredict !== 1'b0) $display("FAIL post_hold_fields got=%b%b want=10", rob_taken, rob_mispredict); else pass_cnt++;
        rob_ready = 1'b1;
        step();
        rob_ready = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        in_valid = 1'b1; in_index = 4'd2; in_result = 2'b01;
        step();
        flush = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0; in_valid = 1'b1;
        step();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        total++; if (holding !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid_hold got=%b/%b want=0/1", holding, in_ready); else pass_cnt++;
        total++; if (rob_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_mid_state got=%b/%b want=0/0", rob_valid, overflow); else pass_cnt++;
    endtask

`ifdef BRA_RESOLVE_STATS_EN
    task automatic test_stats();
        logic [1:0] res [3];
        logic       mis [3];
        res[0] = 2'b11; res[1] = 2'b01; res[2] = 2'b00;
        mis[0] = 1'b0;  mis[1] = 1'b1;  mis[2] = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (stat_resolved !== 16'd0 || stat_mispred !== 16'd0) $display("FAIL stats_reset got=%0d/%0d want=0/0", stat_resolved, stat_mispred); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_index = 4'(10 + i); in_result = res[i];
            step();
        end
        in_valid = 1'b0; rob_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (rob_mispredict !== mis[i]) $display("FAIL stats_head%0d_mis got=%b want=%b", i, rob_mispredict, mis[i]); else pass_cnt++;
            step();
        end
        rob_ready = 1'b0;
        total++; if (stat_resolved !== 16'd3 || stat_mispred !== 16'd1) $display("FAIL stats_count got=%0d/%0d want=3/1", stat_resolved, stat_mispred); else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        total++; if (stat_resolved !== 16'd3 || stat_mispred !== 16'd1) $display("FAIL stats_flush got=%0d/%0d want=3/1", stat_resolved, stat_mispred); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_flush_hold();
        test_reset_mid_hold();
`ifdef BRA_RESOLVE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
